// File: rtl/gpu_pkg.sv
// gpu_pkg: shared framebuffer geometry and the draw sequencer state encoding.
//   FB_COLS / FB_ROWS : framebuffer size in pixels / rows (one RAM word per row)
//   ROW_W / COL_W     : index widths derived from the geometry
//   SPR_W             : sprite row width in pixels (one memory byte)
//   state_t           : draw_ctrl FSM states
package gpu_pkg;

  localparam int FB_COLS = 64;
  localparam int FB_ROWS = 32;
  localparam int ROW_W   = $clog2(FB_ROWS);
  localparam int COL_W   = $clog2(FB_COLS);
  localparam int SPR_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/draw_row_shifter.sv
// draw_row_shifter: places one sprite byte MSB-first at column col of a row.
// Column c maps to row bit (FB_COLS-1-c); pixels past the right edge fall off
// the bottom of the shift, so the mask is clipped, never wrapped.
//   sbyte : sprite row bits, bit 7 is the leftmost pixel
//   col   : start column (already reduced mod FB_COLS)
//   mask  : FB_COLS-wide clipped mask
module draw_row_shifter
  import gpu_pkg::*;
(
  input  logic [SPR_W-1:0]   sbyte,
  input  logic [COL_W-1:0]   col,
  output logic [FB_COLS-1:0] mask
);

  logic [FB_COLS-1:0] at_col0;

  // Byte parked at columns 0..7, then slid right by col.
  assign at_col0 = {sbyte, {(FB_COLS-SPR_W){1'b0}}};
  assign mask    = at_col0 >> col;

endmodule

// File: rtl/draw_ctrl.sv
// draw_ctrl: CLS / DXYN sequencer for the 64x32 monochrome framebuffer.
// Fetches sprite bytes, does read-XOR-write per framebuffer row and reports
// the collision flag for VF. Sole writer of the framebuffer row RAM.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_clear, cmd_draw   : command strobes, sampled only in IDLE (clear wins)
//   x, y, n, i_addr       : DXYN operands (x mod 64, y mod 32, n rows, I)
//   busy, done, vf        : in-progress flag, completion pulse, {7'b0,collision}
//   mem_rd/mem_addr/mem_data : sprite byte port, 1-cycle read latency
//   fb_rd/fb_addr/fb_rdata   : framebuffer row read, 1-cycle read latency
//   fb_we/fb_wdata           : framebuffer row write (shares fb_addr)
module draw_ctrl
  import gpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_clear,
  input  logic               cmd_draw,
  input  logic [7:0]         x,
  input  logic [7:0]         y,
  input  logic [3:0]         n,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               busy,
  output logic               done,
  output logic [7:0]         vf,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [SPR_W-1:0]   mem_data,
  output logic               fb_rd,
  output logic [ROW_W-1:0]   fb_addr,
  input  logic [FB_COLS-1:0] fb_rdata,
  output logic               fb_we,
  output logic [FB_COLS-1:0] fb_wdata
);

  state_t             state;
  logic [COL_W-1:0]   x_q;
  logic [ROW_W-1:0]   y_q;
  logic [3:0]         n_q;
  logic [ADDR_W-1:0]  i_q;
  logic [ROW_W-1:0]   row_q;    // sprite row r, or clear row index
  logic               row_vis;  // current sprite row lands inside the framebuffer
  logic               coll;

  logic [ROW_W-1:0]   row_nxt;
  logic [ROW_W:0]     yr_sum;
  logic [FB_COLS-1:0] mask;
  logic               hit;
  logic               unused_ok;

  // Only the low bits of x/y matter: the operands are taken modulo the size.
  assign unused_ok = ^{x[7:COL_W], y[7:ROW_W]};

  draw_row_shifter u_shift (
    .sbyte (mem_data),
    .col   (x_q),
    .mask  (mask)
  );

  assign row_nxt = row_q + ROW_W'(1);
  // Carry out of y+r means the row is below the bottom edge: clip it.
  assign yr_sum  = {1'b0, y_q} + {1'b0, row_nxt};
  assign hit     = row_vis & (|(fb_rdata & mask));

  // Write data depends on RAM read data arriving in WR, so it is the one
  // output not registered; it never depends on the command inputs.
  assign fb_wdata = (state == WR) ? (fb_rdata ^ mask) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      vf       <= 8'h00;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      fb_rd    <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      n_q      <= '0;
      i_q      <= '0;
      row_q    <= '0;
      row_vis  <= 1'b0;
      coll     <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_rd <= 1'b0;
      fb_rd  <= 1'b0;
      fb_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_clear) begin
            state   <= CLR;
            busy    <= 1'b1;
            row_q   <= '0;
            fb_addr <= '0;
            fb_we   <= 1'b1;
          end else if (cmd_draw) begin
            busy  <= 1'b1;
            x_q   <= x[COL_W-1:0];
            y_q   <= y[ROW_W-1:0];
            n_q   <= n;
            i_q   <= i_addr;
            row_q <= '0;
            coll  <= 1'b0;
            if (n == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
              vf    <= 8'h00;
            end else begin
              // First row is always on screen since y is already mod rows.
              state    <= RD;
              mem_rd   <= 1'b1;
              mem_addr <= i_addr;
              fb_rd    <= 1'b1;
              fb_addr  <= y[ROW_W-1:0];
              row_vis  <= 1'b1;
            end
          end
        end

        CLR: begin
          if (row_q == ROW_W'(FB_ROWS-1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            row_q   <= row_nxt;
            fb_addr <= row_nxt;
            fb_we   <= 1'b1;
          end
        end

        RD: begin
          // fb_addr stays put so WR writes back the row just read.
          state <= WR;
          fb_we <= row_vis;
        end

        WR: begin
          coll  <= coll | hit;
          row_q <= row_nxt;
          if (row_nxt == ROW_W'(n_q)) begin
            state <= DONE;
            done  <= 1'b1;
            vf    <= {7'b0, coll | hit};
          end else begin
            state    <= RD;
            mem_rd   <= 1'b1;
            mem_addr <= i_q + ADDR_W'(row_nxt);
            fb_rd    <= 1'b1;
            fb_addr  <= yr_sum[ROW_W-1:0];
            row_vis  <= ~yr_sum[ROW_W];
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
